// File: rtl/id_exe_stage_buf.sv
// ID->EXE elastic stage: 2-entry buffer (output register + skid register) carrying the decoded bundle.
// Latency: 1 cycle from accept to VALID_OUT when the buffer is EMPTY or ONE.
// Backpressure: READY_OUT depends only on skid occupancy and RESET, so READY_IN/VALID_IN never reach it combinationally.
// Optional feature macro: ID_EXE_PERF_CNT_EN adds PERF_STALL_CNT, a saturating count of stalled cycles.
module id_exe_stage_buf #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int OPERATOR_LEN = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FLUSH,
    // ID side
    input  logic                    VALID_IN,
    output logic                    READY_OUT,
    input  logic [REG_ADDR_LEN-1:0] DEST_IN,
    input  logic [REG_ADDR_LEN-1:0] SRC1_IN,
    input  logic [REG_ADDR_LEN-1:0] SRC2_IN,
    input  logic [OPERATOR_LEN-1:0] OPERATOR_IN,
    input  logic [WORD_LEN-1:0]     REG2_IN,
    input  logic [WORD_LEN-1:0]     OP1_IN,
    input  logic [WORD_LEN-1:0]     OP2_IN,
    input  logic [WORD_LEN-1:0]     PC_IN,
    input  logic                    MEM_RD_IN,
    input  logic                    MEM_WR_IN,
    input  logic                    WB_EN_IN,
    input  logic                    BR_TAKEN_IN,
    // EXE side
    output logic                    VALID_OUT,
    input  logic                    READY_IN,
    output logic [REG_ADDR_LEN-1:0] DEST_OUT,
    output logic [REG_ADDR_LEN-1:0] SRC1_OUT,
    output logic [REG_ADDR_LEN-1:0] SRC2_OUT,
    output logic [OPERATOR_LEN-1:0] OPERATOR_OUT,
    output logic [WORD_LEN-1:0]     SW_OPERAND_OUT,
    output logic [WORD_LEN-1:0]     OP1_OUT,
    output logic [WORD_LEN-1:0]     OP2_OUT,
    output logic [WORD_LEN-1:0]     PC_OUT,
    output logic                    MEM_RD_OUT,
    output logic                    MEM_WR_OUT,
    output logic                    WB_EN_OUT,
    output logic                    BR_TAKEN_OUT
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [31:0]             PERF_STALL_CNT
`endif
);

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] dest;
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [OPERATOR_LEN-1:0] op;
        logic [WORD_LEN-1:0]     reg2;
        logic [WORD_LEN-1:0]     op1;
        logic [WORD_LEN-1:0]     op2;
        logic [WORD_LEN-1:0]     pc;
        logic                    mem_rd;
        logic                    mem_wr;
        logic                    wb_en;
        logic                    br_taken;
    } bundle_t;

    bundle_t r_out;
    bundle_t r_skid;
    logic    r_out_vld;
    logic    r_skid_vld;

    bundle_t w_in;
    logic    w_accept;
    logic    w_consume;
    logic    w_load_out_in;
    logic    w_load_out_skid;
    logic    w_load_skid;

    assign w_in = '{
        dest:     DEST_IN,
        src1:     SRC1_IN,
        src2:     SRC2_IN,
        op:       OPERATOR_IN,
        reg2:     REG2_IN,
        op1:      OP1_IN,
        op2:      OP2_IN,
        pc:       PC_IN,
        mem_rd:   MEM_RD_IN,
        mem_wr:   MEM_WR_IN,
        wb_en:    WB_EN_IN,
        br_taken: BR_TAKEN_IN
    };

    // Ready is purely a function of skid occupancy; an empty skid can always absorb one more bundle.
    assign READY_OUT = ~r_skid_vld & ~RESET;

    assign w_accept  = VALID_IN & READY_OUT;
    assign w_consume = r_out_vld & READY_IN;

    // Accept never coincides with a full skid, so the input either goes straight to the output
    // register (it is empty or being drained) or parks in the skid.
    assign w_load_out_in   = w_accept & (~r_out_vld | w_consume);
    assign w_load_out_skid = w_consume & r_skid_vld;
    assign w_load_skid     = w_accept & r_out_vld & ~w_consume;

    // Valid bits: flush squashes everything held and drops the incoming bundle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (FLUSH) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            if (w_load_out_in || w_load_out_skid) begin
                r_out_vld <= 1'b1;
            end else if (w_consume) begin
                r_out_vld <= 1'b0;
            end

            if (w_load_skid) begin
                r_skid_vld <= 1'b1;
            end else if (w_consume) begin
                r_skid_vld <= 1'b0;
            end
        end
    end

    // Payload registers: only written on a real transfer so data fields hold while invalid or stalled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out  <= '0;
            r_skid <= '0;
        end else if (!FLUSH) begin
            if (w_load_out_skid) begin
                r_out <= r_skid;
            end else if (w_load_out_in) begin
                r_out <= w_in;
            end

            if (w_load_skid) begin
                r_skid <= w_in;
            end
        end
    end

    assign VALID_OUT      = r_out_vld;
    assign DEST_OUT       = r_out.dest;
    assign SRC1_OUT       = r_out.src1;
    assign SRC2_OUT       = r_out.src2;
    assign OPERATOR_OUT   = r_out.op;
    assign SW_OPERAND_OUT = r_out.reg2;
    assign OP1_OUT        = r_out.op1;
    assign OP2_OUT        = r_out.op2;
    assign PC_OUT         = r_out.pc;

    // Control enables are gated so EXE never sees a side effect from a stale bundle.
    assign MEM_RD_OUT     = r_out.mem_rd   & r_out_vld;
    assign MEM_WR_OUT     = r_out.mem_wr   & r_out_vld;
    assign WB_EN_OUT      = r_out.wb_en    & r_out_vld;
    assign BR_TAKEN_OUT   = r_out.br_taken & r_out_vld;

`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating stall counter; survives FLUSH so squashes do not hide backpressure history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (r_out_vld && !READY_IN && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign PERF_STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_exe_stage_buf.sv
// Directed bench for id_exe_stage_buf with a bundle scoreboard.
// Expected bundles are queued on accept and compared on every consume.
// Flush empties the scoreboard; reset clears it as well.
module tb_id_exe_stage_buf;

    logic        CLK;
    logic        RESET;
    logic        FLUSH;
    logic        VALID_IN;
    logic        READY_OUT;
    logic [4:0]  DEST_IN, SRC1_IN, SRC2_IN;
    logic [3:0]  OPERATOR_IN;
    logic [31:0] REG2_IN, OP1_IN, OP2_IN, PC_IN;
    logic        MEM_RD_IN, MEM_WR_IN, WB_EN_IN, BR_TAKEN_IN;
    logic        VALID_OUT;
    logic        READY_IN;
    logic [4:0]  DEST_OUT, SRC1_OUT, SRC2_OUT;
    logic [3:0]  OPERATOR_OUT;
    logic [31:0] SW_OPERAND_OUT, OP1_OUT, OP2_OUT, PC_OUT;
    logic        MEM_RD_OUT, MEM_WR_OUT, WB_EN_OUT, BR_TAKEN_OUT;
`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] PERF_STALL_CNT;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [150:0] sb[$];

    id_exe_stage_buf #(
        .WORD_LEN(32), .REG_ADDR_LEN(5), .OPERATOR_LEN(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
        .DEST_IN(DEST_IN), .SRC1_IN(SRC1_IN), .SRC2_IN(SRC2_IN),
        .OPERATOR_IN(OPERATOR_IN), .REG2_IN(REG2_IN), .OP1_IN(OP1_IN),
        .OP2_IN(OP2_IN), .PC_IN(PC_IN),
        .MEM_RD_IN(MEM_RD_IN), .MEM_WR_IN(MEM_WR_IN), .WB_EN_IN(WB_EN_IN),
        .BR_TAKEN_IN(BR_TAKEN_IN),
        .VALID_OUT(VALID_OUT), .READY_IN(READY_IN),
        .DEST_OUT(DEST_OUT), .SRC1_OUT(SRC1_OUT), .SRC2_OUT(SRC2_OUT),
        .OPERATOR_OUT(OPERATOR_OUT), .SW_OPERAND_OUT(SW_OPERAND_OUT),
        .OP1_OUT(OP1_OUT), .OP2_OUT(OP2_OUT), .PC_OUT(PC_OUT),
        .MEM_RD_OUT(MEM_RD_OUT), .MEM_WR_OUT(MEM_WR_OUT), .WB_EN_OUT(WB_EN_OUT),
        .BR_TAKEN_OUT(BR_TAKEN_OUT)
`ifdef ID_EXE_PERF_CNT_EN
        , .PERF_STALL_CNT(PERF_STALL_CNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic logic [150:0] out_vec();
        return {DEST_OUT, SRC1_OUT, SRC2_OUT, OPERATOR_OUT, SW_OPERAND_OUT,
                OP1_OUT, OP2_OUT, PC_OUT, MEM_RD_OUT, MEM_WR_OUT, WB_EN_OUT, BR_TAKEN_OUT};
    endfunction

    function automatic logic [150:0] in_vec();
        return {DEST_IN, SRC1_IN, SRC2_IN, OPERATOR_IN, REG2_IN,
                OP1_IN, OP2_IN, PC_IN, MEM_RD_IN, MEM_WR_IN, WB_EN_IN, BR_TAKEN_IN};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bundle(input logic [31:0] pc);
        DEST_IN     = 5'($urandom);
        SRC1_IN     = 5'($urandom);
        SRC2_IN     = 5'($urandom);
        OPERATOR_IN = 4'($urandom);
        REG2_IN     = $urandom;
        OP1_IN      = $urandom;
        OP2_IN      = $urandom;
        PC_IN       = pc;
        MEM_RD_IN   = 1'($urandom);
        MEM_WR_IN   = 1'($urandom);
        WB_EN_IN    = 1'($urandom);
        BR_TAKEN_IN = 1'($urandom);
    endtask

    // Samples the handshake with inputs settled, updates the scoreboard, then crosses one rising edge.
    task automatic tick();
        logic acc, con;
        acc = VALID_IN & READY_OUT & ~FLUSH & ~RESET;
        con = VALID_OUT & READY_IN & ~RESET;
        if (con) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_consume", 160'(PC_OUT), 160'hFFFF_FFFF_FFFF);
            end else begin
                chk("sb_bundle", 160'(out_vec()), 160'(sb.pop_front()));
            end
        end
        if (acc) sb.push_back(in_vec());
        if (RESET || FLUSH) sb.delete();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; VALID_IN = 1'b1; READY_IN = 1'b0;
        set_bundle(32'h0000_00AA);

        // 1. reset with VALID_IN high
        tick();
        chk("rst_valid_out", 160'(VALID_OUT), 160'(0));
        chk("rst_ready_out", 160'(READY_OUT), 160'(0));
        tick();
        chk("rst_bundle_zero", 160'(out_vec()), 160'(0));
        chk("rst_ready_out2", 160'(READY_OUT), 160'(0));
        RESET = 1'b0; VALID_IN = 1'b0;
        tick();
        chk("post_rst_ready", 160'(READY_OUT), 160'(1));
        chk("post_rst_valid", 160'(VALID_OUT), 160'(0));

        // 2. streaming with 1-cycle lag
        READY_IN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_bundle(32'(i * 4));
            VALID_IN = 1'b1;
            tick();
            chk("stream_pc", 160'(PC_OUT), 160'(i * 4));
            chk("stream_valid", 160'(VALID_OUT), 160'(1));
            chk("stream_ready", 160'(READY_OUT), 160'(1));
        end
        VALID_IN = 1'b0;
        tick();
        chk("stream_drained", 160'(VALID_OUT), 160'(0));

        // 3. backpressure fills the skid
        READY_IN = 1'b0; VALID_IN = 1'b1;
        set_bundle(32'h10); tick();
        set_bundle(32'h14); tick();
        chk("bp_pc_head", 160'(PC_OUT), 160'h10);
        chk("bp_ready_low", 160'(READY_OUT), 160'(0));
        set_bundle(32'h99); tick(); tick();
        chk("bp_hold", 160'(out_vec()), 160'(sb[0]));
        chk("bp_ready_low2", 160'(READY_OUT), 160'(0));
        VALID_IN = 1'b0; READY_IN = 1'b1;
        tick();
        chk("bp_second_pc", 160'(PC_OUT), 160'h14);
        chk("bp_ready_back", 160'(READY_OUT), 160'(1));
        tick();
        chk("bp_empty", 160'(VALID_OUT), 160'(0));

        // 4. flush while FULL with a bundle presented
        READY_IN = 1'b0; VALID_IN = 1'b1;
        set_bundle(32'h20); MEM_WR_IN = 1'b1; WB_EN_IN = 1'b1; tick();
        set_bundle(32'h24); MEM_WR_IN = 1'b1; WB_EN_IN = 1'b1; tick();
        chk("fl_full", 160'(READY_OUT), 160'(0));
        FLUSH = 1'b1; set_bundle(32'h18); WB_EN_IN = 1'b1; tick();
        FLUSH = 1'b0; VALID_IN = 1'b0;
        chk("fl_valid", 160'(VALID_OUT), 160'(0));
        chk("fl_ctrl", 160'({WB_EN_OUT, MEM_WR_OUT}), 160'(0));
        chk("fl_ready", 160'(READY_OUT), 160'(1));
        READY_IN = 1'b1;
        tick(); tick();
        chk("fl_no_ghost", 160'(VALID_OUT), 160'(0));

        // flush in ONE with accept true and a concurrent legal consume
        VALID_IN = 1'b1; set_bundle(32'h30); tick();
        FLUSH = 1'b1; set_bundle(32'h1C); tick();
        FLUSH = 1'b0; VALID_IN = 1'b0;
        chk("fl1_valid", 160'(VALID_OUT), 160'(0));
        chk("fl1_ready", 160'(READY_OUT), 160'(1));
        tick();
        chk("fl1_no_ghost", 160'(VALID_OUT), 160'(0));

        // 5. control qualification
        set_bundle(32'h40); WB_EN_IN = 1'b1; VALID_IN = 1'b0; READY_IN = 1'b0;
        tick();
        chk("q_wb_invalid", 160'(WB_EN_OUT), 160'(0));
        VALID_IN = 1'b1; OP1_IN = 32'hDEAD_BEEF; DEST_IN = 5'd31; WB_EN_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        chk("q_op1", 160'(OP1_OUT), 160'hDEAD_BEEF);
        chk("q_dest", 160'(DEST_OUT), 160'd31);
        chk("q_wb_valid", 160'(WB_EN_OUT), 160'(1));
        READY_IN = 1'b1;
        tick();
        chk("q_wb_gated", 160'(WB_EN_OUT), 160'(0));
        chk("q_data_hold", 160'(OP1_OUT), 160'hDEAD_BEEF);

`ifdef ID_EXE_PERF_CNT_EN
        // 6. stall counter
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("pc_reset", 160'(PERF_STALL_CNT), 160'(0));
        READY_IN = 1'b0; VALID_IN = 1'b1; set_bundle(32'h50); tick();
        VALID_IN = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pc_seven", 160'(PERF_STALL_CNT), 160'(7));
        READY_IN = 1'b1; FLUSH = 1'b1; tick(); FLUSH = 1'b0;
        chk("pc_after_flush", 160'(PERF_STALL_CNT), 160'(7));
        chk("pc_flush_valid", 160'(VALID_OUT), 160'(0));
`endif

        chk("sb_leftover", 160'(sb.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
